// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Byte stride between consecutive instruction words.
  localparam int unsigned INSTR_BYTES = 4;

  // Default datapath widths of the core this unit plugs into.
  localparam int unsigned DEF_PC_WIDTH    = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;

  // One prefetched instruction tagged with its fetch address.
  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0]    pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding {pc, instr} entries.
// Flush wins over push; a pop in the flush cycle is simply absorbed by the flush.
// The head entry is presented combinationally so decode sees it with no extra latency.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0);

  // Next pointer and occupancy values; flush returns everything to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order reads to instruction
// memory, buffers responses in a prefetch FIFO and hands them to decode.
// Redirects flush the FIFO and retire in-flight wrong-path responses in DRAIN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          INSTR_WIDTH  = 32,
  parameter int unsigned          FIFO_DEPTH   = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PC_WIDTH-1:0]    mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc
);

  localparam int unsigned         CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_BYTES);

  // Same layout as fetch_entry_t but sized by this instance's parameters.
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [CW-1:0]       stale_q, stale_d;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         credit_used;
  logic [PC_WIDTH-1:0] target_pc;
  logic                req_fire;
  logic                rsp_fire;
  logic                redirect_fire;
  logic                push;
  logic                pop;
  entry_t              fifo_wdata;
  entry_t              fifo_rdata;

  // Requests in flight plus entries already buffered may never exceed the FIFO size,
  // so every accepted request is guaranteed a slot when its response returns.
  assign credit_used   = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign target_pc     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign redirect_fire = redirect_valid && (state_q != IDLE);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_fire      = mem_rsp_valid && (outstanding_q != '0);
  assign pop           = out_valid && out_ready;
  // Stale responses and anything arriving alongside a redirect are wrong-path.
  assign push          = rsp_fire && (stale_q == '0) && !redirect_fire;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: stay in DRAIN while wrong-path responses are still owed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = FETCH;
      FETCH, DRAIN: state_d = (stale_d != '0) ? DRAIN : FETCH;
      default:      state_d = IDLE;
    endcase
  end

  // FSM outputs, derived only from registered state.
  always_comb begin
    mem_req_valid = (state_q == FETCH) && (credit_used < (CW + 1)'(FIFO_DEPTH));
    mem_req_addr  = pc_q;
    out_valid     = (fifo_count != '0);
    out_instr     = fifo_rdata.instr;
    out_pc        = fifo_rdata.pc;
  end

  // Datapath next state: PC advance, response tagging and stale accounting.
  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    stale_d       = stale_q;
    if (redirect_fire) begin
      // A request accepted this very cycle already went down the old path.
      pc_d     = target_pc;
      rsp_pc_d = target_pc;
      stale_d  = outstanding_d;
    end else begin
      if (req_fire) pc_d = pc_q + PC_STEP;
      if (push) rsp_pc_d = rsp_pc_q + PC_STEP;
      if (rsp_fire && (stale_q != '0)) stale_d = stale_q - CW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  assign fifo_wdata.pc    = rsp_pc_q;
  assign fifo_wdata.instr = mem_rsp_data;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_fire),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Parametrised instruction fetch unit replacing the bare free-running PC of the single-cycle core. Holds the program counter, issues in-order read requests to instruction memory through a valid/ready port, buffers returned instructions in a small prefetch FIFO and presents them with their PC to decode. Accepts branch/jump redirects and discards in-flight responses fetched down the wrong path.

## Interface
- PC_WIDTH, 32: width of PC, memory address and redirect target
- INSTR_WIDTH, 32: instruction word width
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, at least 2; also the cap on outstanding plus buffered fetches
- RESET_VECTOR, 0: PC loaded on reset; low 2 bits must be 0
- One clock, `clk`. Reset `rst` is asynchronous and active-low. These are the first two ports below.
- clk  in  1  clock
- rst  in  1  async active-low reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_WIDTH  target; bits [1:0] ignored (treated as 0)
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  PC_WIDTH  fetch byte address
- mem_rsp_valid  in  1  in-order read response, at least 1 cycle after acceptance
- mem_rsp_data  in  INSTR_WIDTH  response word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes
- out_instr  out  INSTR_WIDTH  FIFO head instruction
- out_pc  out  PC_WIDTH  address of out_instr

## Operation
- FSM states: IDLE (reset state), FETCH, DRAIN.
  - IDLE -> FETCH unconditionally on the first clock after rst deasserts.
  - FETCH -> DRAIN on a redirect when in-flight stale requests remain after that cycle.
  - DRAIN -> FETCH when stale_cnt reaches 0 and no new redirect arrives.
- Registers:
  - pc: next fetch address.
  - rsp_pc: address of the next expected good response.
  - outstanding: accepted requests not yet answered.
  - stale_cnt: outstanding responses to discard.
  - FIFO count.
  - All counters are $clog2(FIFO_DEPTH+1) bits wide.
- mem_req_valid = (state==FETCH) && (outstanding + fifo_count < FIFO_DEPTH); mem_req_addr = pc. Both are driven only from registers.
- Request accepted (valid && ready): pc += 4, outstanding += 1.
- Response: outstanding -= 1.
  - If stale_cnt > 0: stale_cnt -= 1 and the data is dropped.
  - Otherwise: push {rsp_pc, data} into the FIFO and rsp_pc += 4.
- Output handshake (out_valid && out_ready): pop the FIFO.
- Redirect (any state except IDLE):
  - pc, rsp_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - FIFO flushed.
  - stale_cnt <= outstanding + (request accepted this cycle) - (response this cycle).
  - No request is issued in a redirect cycle (mem_req_valid is still computed from registers; a request accepted that cycle counts as stale).
- Simultaneous events:
  - Redirect with response: the response is dropped.
  - Redirect with output handshake: the pop completes, then the flush.
  - Push and pop in the same cycle with the FIFO full: allowed. The credit rule prevents overflow.
- PC arithmetic is modulo 2^PC_WIDTH; 0xFFFF_FFFC + 4 wraps to 0.
- Reset mid-operation: all state is cleared immediately. Late memory responses arriving after reset are a system error; no behaviour is defined.

## Timing
- Reset values:
  - mem_req_valid=0, mem_req_addr=RESET_VECTOR.
  - out_valid=0, out_instr=0, out_pc=0.
  - state=IDLE, all counters 0.
- First request is visible on the 1st rising edge after rst deasserts (the IDLE->FETCH edge).
- Response-to-output latency is 1 cycle: a response at edge N makes out_valid=1 after edge N.
- Zero-wait memory sustains one instruction per cycle with out_ready held high.
- After a redirect at edge N, the target request is presented after edge N if stale_cnt==0, else after the edge at which the last stale response retires.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_e` enum {IDLE, FETCH, DRAIN}
  - `INSTR_BYTES=4` constant
  - `fetch_entry_t` struct {pc, instr}
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, flush and count. Flush has priority over push.

## Test plan
- Reset with RESET_VECTOR=0x100, zero-wait memory, out_ready=1 -> request addresses 0x100, 0x104, 0x108…; out_pc follows one cycle behind the response, with out_instr matching memory.
- out_ready=0 with 1-cycle memory, FIFO_DEPTH=4 -> exactly 4 requests accepted. mem_req_valid falls once outstanding+count=4 and resumes one per pop.
- Memory latency 3 with 3 requests outstanding; redirect to 0x2002 -> 3 responses dropped in DRAIN. Next request is 0x2000; first out_pc is 0x2000.
- Redirect in the same cycle as a response and an out handshake -> the handshake completes, the response is not enqueued and the FIFO is empty next cycle.
- pc=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream with FIFO non-empty -> out_valid=0 and mem_req_valid=0 immediately; fetch restarts at RESET_VECTOR after release.
